pipeline_ctrl: RTL and testbench
================================

# pipeline_ctrl

Hazard and sequencing controller for the three-stage MIPS150 pipeline: X (fetch/decode/register read), Y (execute/memory), Z (writeback). It produces the stall, bubble and flush strobes and the operand-forwarding selects for the datapath. It also handles the memory-mapped UART handshake for Y-stage loads and stores. It sits beside `ControlUnit` and takes its inputs from the X/Y/Z pipeline registers.

## Interface
Parameters:
- `IO_TIMEOUT`, default 65535: IO_WAIT cycles before `io_timeout` is raised. Must be 1..65535.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall` in 1: external freeze, highest priority.
- `rs_x`, `rt_x` in 5 each: source registers of the X instruction.
- `use_rs_x`, `use_rt_x` in 1 each: the X instruction reads `rs_x` / `rt_x`.
- `wa_y` in 5, `regwrite_y` in 1, `memtoreg_y` in 1: Y destination register, write enable, load flag.
- `wa_z` in 5, `regwrite_z` in 1: Z destination register and write enable.
- `branch_taken_y` in 1: Y redirects the PC.
- `uart_rd_y`, `uart_wr_y` in 1 each: Y is a UART data load / store.
- `rx_valid`, `tx_ready` in 1 each: UART DataOutValid / DataInReady.
- `stall_pc`, `stall_x`, `stall_y` out 1 each: hold the register.
- `bubble_y` out 1: load a NOP into the Y register.
- `flush_x` out 1: replace the X instruction with a NOP.
- `fwd_a`, `fwd_b` out 2 each: operand select. 0 = register file, 1 = Y ALU result, 2 = Z writeback data.
- `rx_ack` out 1: DataOutReady pulse.
- `tx_strobe` out 1: DataInValid pulse.
- `io_timeout` out 1: sticky timeout flag.

## Operation
- All outputs are combinational from the state, `stall` and the inputs, except `io_timeout`, which is registered.
- FSM states: RUN, LD_STALL, IO_WAIT. Reset state is RUN.

Helper terms:
- `ldu` = `memtoreg_y` & `regwrite_y` & `wa_y`≠0 & ((`use_rs_x` & `rs_x`==`wa_y`) | (`use_rt_x` & `rt_x`==`wa_y`)).
- `iob` = (`uart_rd_y` & !`rx_valid`) | (`uart_wr_y` & !`tx_ready`).

State behaviour:
- RUN, `iob`=1: assert `stall_pc`, `stall_x`, `stall_y`. Next state IO_WAIT.
- RUN, otherwise `ldu`=1: assert `stall_pc`, `stall_x`, `bubble_y`. Next state LD_STALL.
- RUN, neither: normal flow, stay in RUN.
- LD_STALL: no hazard detection for one cycle; Y holds the bubble. Next state RUN.
- IO_WAIT: `stall_pc`, `stall_x`, `stall_y` stay asserted while `iob`=1. The first cycle `iob`=0 releases the stalls and returns to RUN.
- IO_WAIT wait counter: 16 bits, cleared on entry. When it reaches `IO_TIMEOUT`, `io_timeout` sets and holds until `rst`. The pipeline keeps waiting after the timeout.

UART handshake:
- `rx_ack` = `uart_rd_y` & `rx_valid` & !`stall`. It asserts on exactly one cycle per read.
- `tx_strobe` = `uart_wr_y` & `tx_ready` & !`stall`.

Branches and flushes:
- `flush_x` = `branch_taken_y` & !`iob` & !`stall`.
- A branch in Y cannot coexist with `ldu`: branches write no register.

Forwarding (per operand; `fwd_a` uses `rs_x`, `fwd_b` uses `rt_x`):
- Select 1 if `regwrite_y` & !`memtoreg_y` & `wa_y`≠0 & match.
- Else select 2 if `regwrite_z` & `wa_z`≠0 & match.
- Else select 0.
- Y takes priority over Z.
- Register 0 is never forwarded.

External stall:
- `stall`=1 asserts `stall_pc`, `stall_x`, `stall_y`.
- It forces `bubble_y`, `flush_x`, `rx_ack` and `tx_strobe` to 0.
- The FSM and counters hold.

## Timing
- All outputs are zero-latency with respect to the inputs.
- Load-use hazard costs exactly 1 stall cycle.
- IO stall length = cycles until `rx_valid` / `tx_ready` rises; the instruction completes in that same cycle.
- Reset: state = RUN, wait counter = 0, `io_timeout` = 0.
- While `rst`=1: `flush_x`=1, all other outputs 0.
- Reset asserted in IO_WAIT or LD_STALL returns to RUN on the next edge.
- Simultaneous events:
  - `ldu` and `iob` in the same cycle: `iob` wins. `ldu` is re-evaluated on return to RUN.
  - `branch_taken_y` while in IO_WAIT: flush is deferred until `iob` clears.

## Configuration
- `PIPELINE_CTRL_PERF_EN` defined: adds these ports:
  - `cycle_cnt` out 32: non-reset cycles.
  - `stall_cnt` out 32: cycles with any `stall_*` asserted by this block.
  - `flush_cnt` out 32: `flush_x` pulses.
- The counters reset to 0, wrap at 2^32, and hold while `stall`=1.
- Undefined: no counters and no counter ports.

## Test plan
- Load to r5 in Y; X reads `rs_x`=5 → one cycle of `stall_pc`/`stall_x`/`bubble_y`=1, then LD_STALL, then RUN with `fwd_a`=2.
- ALU write to r3 in Y and to r3 in Z; X reads `rt_x`=3 → `fwd_b`=1. With `wa_y`=0 instead → `fwd_b`=2.
- `uart_rd_y`=1, `rx_valid` low for 5 cycles → stalls held 5 cycles; `rx_ack` pulses once in cycle 6; state back to RUN.
- `IO_TIMEOUT`=4, `tx_ready` held low → `io_timeout`=1 after 4 IO_WAIT cycles and stays 1 after `tx_ready` rises; cleared only by `rst`.
- `branch_taken_y`=1 with `stall`=1 → `flush_x`=0. Release `stall` → `flush_x`=1 for 1 cycle.
- `rst` asserted mid-IO_WAIT → next cycle state RUN, all stalls 0; with PERF_EN, `cycle_cnt`=0.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the X/Y/Z MIPS pipeline: stalls, bubbles, flushes, forwarding selects, UART handshake.
// Latency: strobes and selects are combinational (zero cycles); io_timeout and the optional counters are registered.
// Backpressure: UART not-ready freezes PC/X/Y until ready; external stall overrides all. Option macro: PIPELINE_CTRL_PERF_EN.
module pipeline_ctrl #(
    parameter int unsigned IO_TIMEOUT = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic [4:0] rs_x,
    input  logic [4:0] rt_x,
    input  logic       use_rs_x,
    input  logic       use_rt_x,
    input  logic [4:0] wa_y,
    input  logic       regwrite_y,
    input  logic       memtoreg_y,
    input  logic [4:0] wa_z,
    input  logic       regwrite_z,
    input  logic       branch_taken_y,
    input  logic       uart_rd_y,
    input  logic       uart_wr_y,
    input  logic       rx_valid,
    input  logic       tx_ready,
    output logic       stall_pc,
    output logic       stall_x,
    output logic       stall_y,
    output logic       bubble_y,
    output logic       flush_x,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       rx_ack,
    output logic       tx_strobe,
    output logic       io_timeout
`ifdef PIPELINE_CTRL_PERF_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {RUN = 2'd0, LD_STALL = 2'd1, IO_WAIT = 2'd2} state_t;

    localparam logic [16:0] TIMEOUT_LIM = 17'(IO_TIMEOUT);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] wait_cnt;
    logic [16:0] wait_inc;
    logic        ldu;
    logic        iob;
    logic        hold_front;
    logic        hold_y;
    logic        bubble;
    logic        y_hit_a, y_hit_b, z_hit_a, z_hit_b;

    assign ldu = memtoreg_y & regwrite_y & (wa_y != 5'd0) &
                 ((use_rs_x & (rs_x == wa_y)) | (use_rt_x & (rt_x == wa_y)));
    assign iob = (uart_rd_y & ~rx_valid) | (uart_wr_y & ~tx_ready);

    // Loads are never forwarded from Y; their data only exists once they reach Z.
    assign y_hit_a = regwrite_y & ~memtoreg_y & (wa_y != 5'd0) & (rs_x == wa_y);
    assign y_hit_b = regwrite_y & ~memtoreg_y & (wa_y != 5'd0) & (rt_x == wa_y);
    assign z_hit_a = regwrite_z & (wa_z != 5'd0) & (rs_x == wa_z);
    assign z_hit_b = regwrite_z & (wa_z != 5'd0) & (rt_x == wa_z);

    assign wait_inc = {1'b0, wait_cnt} + 17'd1;

    always_comb begin
        state_nxt  = state;
        hold_front = 1'b0;
        hold_y     = 1'b0;
        bubble     = 1'b0;
        case (state)
            RUN: begin
                if (iob) begin
                    hold_front = 1'b1;
                    hold_y     = 1'b1;
                    state_nxt  = IO_WAIT;
                end else if (ldu) begin
                    hold_front = 1'b1;
                    bubble     = 1'b1;
                    state_nxt  = LD_STALL;
                end
            end
            LD_STALL: state_nxt = RUN;
            IO_WAIT: begin
                if (iob) begin
                    hold_front = 1'b1;
                    hold_y     = 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        stall_pc  = 1'b0;
        stall_x   = 1'b0;
        stall_y   = 1'b0;
        bubble_y  = 1'b0;
        flush_x   = 1'b0;
        fwd_a     = 2'd0;
        fwd_b     = 2'd0;
        rx_ack    = 1'b0;
        tx_strobe = 1'b0;
        if (rst) begin
            flush_x = 1'b1;
        end else begin
            fwd_a = y_hit_a ? 2'd1 : (z_hit_a ? 2'd2 : 2'd0);
            fwd_b = y_hit_b ? 2'd1 : (z_hit_b ? 2'd2 : 2'd0);
            if (stall) begin
                stall_pc = 1'b1;
                stall_x  = 1'b1;
                stall_y  = 1'b1;
            end else begin
                stall_pc  = hold_front;
                stall_x   = hold_front;
                stall_y   = hold_y;
                bubble_y  = bubble;
                flush_x   = branch_taken_y & ~iob;
                rx_ack    = uart_rd_y & rx_valid;
                tx_strobe = uart_wr_y & tx_ready;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            wait_cnt   <= 16'd0;
            io_timeout <= 1'b0;
        end else if (!stall) begin
            state <= state_nxt;
            if (state == RUN && state_nxt == IO_WAIT) begin
                wait_cnt <= 16'd0;
            end else if (state == IO_WAIT && iob) begin
                if (wait_cnt != 16'hFFFF)
                    wait_cnt <= wait_inc[15:0];
                if (wait_inc == TIMEOUT_LIM)
                    io_timeout <= 1'b1;
            end
        end
    end

`ifdef PIPELINE_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= 32'd0;
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else if (!stall) begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (stall_pc | stall_x | stall_y)
                stall_cnt <= stall_cnt + 32'd1;
            if (flush_x)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`else
    // Performance counters compiled out.
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: hazards, forwarding, UART waits, timeout, external stall, reset.
// Built with IO_TIMEOUT=4 so the timeout path is reachable in a few cycles.
module tb_pipeline_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic [4:0] rs_x, rt_x, wa_y, wa_z;
    logic       use_rs_x, use_rt_x, regwrite_y, memtoreg_y, regwrite_z;
    logic       branch_taken_y, uart_rd_y, uart_wr_y, rx_valid, tx_ready;
    logic       stall_pc, stall_x, stall_y, bubble_y, flush_x;
    logic [1:0] fwd_a, fwd_b;
    logic       rx_ack, tx_strobe, io_timeout;
`ifdef PIPELINE_CTRL_PERF_EN
    logic [31:0] cycle_cnt, stall_cnt, flush_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.IO_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .rs_x(rs_x), .rt_x(rt_x), .use_rs_x(use_rs_x), .use_rt_x(use_rt_x),
        .wa_y(wa_y), .regwrite_y(regwrite_y), .memtoreg_y(memtoreg_y),
        .wa_z(wa_z), .regwrite_z(regwrite_z), .branch_taken_y(branch_taken_y),
        .uart_rd_y(uart_rd_y), .uart_wr_y(uart_wr_y), .rx_valid(rx_valid), .tx_ready(tx_ready),
        .stall_pc(stall_pc), .stall_x(stall_x), .stall_y(stall_y), .bubble_y(bubble_y),
        .flush_x(flush_x), .fwd_a(fwd_a), .fwd_b(fwd_b), .rx_ack(rx_ack),
        .tx_strobe(tx_strobe), .io_timeout(io_timeout)
`ifdef PIPELINE_CTRL_PERF_EN
        , .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        stall = 0; rs_x = 0; rt_x = 0; use_rs_x = 0; use_rt_x = 0;
        wa_y = 0; regwrite_y = 0; memtoreg_y = 0; wa_z = 0; regwrite_z = 0;
        branch_taken_y = 0; uart_rd_y = 0; uart_wr_y = 0; rx_valid = 0; tx_ready = 0;
    endtask

    task automatic do_reset;
        rst = 1;
        clear_inputs();
        tick();
        rst = 0;
        #1;
    endtask

    task automatic test_reset;
        rst = 1;
        clear_inputs();
        regwrite_y = 1; wa_y = 2; rs_x = 2; uart_rd_y = 1;
        tick();
        checks++; if (flush_x !== 1'b1) begin errors++; $display("FAIL rst_flush: got %b want 1", flush_x); end
        checks++; if ({stall_pc, stall_x, stall_y, bubble_y} !== 4'b0000) begin errors++; $display("FAIL rst_stalls: got %b want 0000", {stall_pc, stall_x, stall_y, bubble_y}); end
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL rst_fwd_a: got %0d want 0", fwd_a); end
        checks++; if (io_timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %b want 0", io_timeout); end
        rst = 0; uart_rd_y = 0;
        #1;
        checks++; if (flush_x !== 1'b0) begin errors++; $display("FAIL post_rst_flush: got %b want 0", flush_x); end
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL post_rst_fwd_a: got %0d want 1", fwd_a); end
`ifdef PIPELINE_CTRL_PERF_EN
        checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL rst_cycle_cnt: got %0d want 0", cycle_cnt); end
`endif
    endtask

    task automatic test_load_use;
        do_reset();
        regwrite_y = 1; memtoreg_y = 1; wa_y = 5; rs_x = 5; use_rs_x = 1;
        #1;
        checks++; if ({stall_pc, stall_x, bubble_y, stall_y} !== 4'b1110) begin errors++; $display("FAIL ldu_strobes: got %b want 1110", {stall_pc, stall_x, bubble_y, stall_y}); end
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL ldu_fwd_a: got %0d want 0", fwd_a); end
        tick();
        regwrite_z = 1; wa_z = 5;
        #1;
        checks++; if ({stall_pc, stall_x, bubble_y} !== 3'b000) begin errors++; $display("FAIL ld_stall_quiet: got %b want 000", {stall_pc, stall_x, bubble_y}); end
        checks++; if (fwd_a !== 2'd2) begin errors++; $display("FAIL ld_stall_fwd_a: got %0d want 2", fwd_a); end
        tick();
        checks++; if (bubble_y !== 1'b1) begin errors++; $display("FAIL ldu_rearm: got %b want 1", bubble_y); end
        clear_inputs();
        tick();
        tick();
    endtask

    task automatic test_forwarding;
        do_reset();
        regwrite_y = 1; wa_y = 3; regwrite_z = 1; wa_z = 3;
        rs_x = 3; use_rs_x = 1; rt_x = 3; use_rt_x = 1;
        #1;
        checks++; if (fwd_b !== 2'd1) begin errors++; $display("FAIL fwd_b_y: got %0d want 1", fwd_b); end
        checks++; if (fwd_a !== 2'd1) begin errors++; $display("FAIL fwd_a_y: got %0d want 1", fwd_a); end
        checks++; if (stall_pc !== 1'b0) begin errors++; $display("FAIL fwd_no_stall: got %b want 0", stall_pc); end
        wa_y = 0;
        #1;
        checks++; if (fwd_b !== 2'd2) begin errors++; $display("FAIL fwd_b_z: got %0d want 2", fwd_b); end
        rs_x = 7;
        #1;
        checks++; if (fwd_a !== 2'd0) begin errors++; $display("FAIL fwd_a_none: got %0d want 0", fwd_a); end
        wa_z = 0; rt_x = 0;
        #1;
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL fwd_b_r0: got %0d want 0", fwd_b); end
        regwrite_y = 0; wa_y = 4; wa_z = 4; rt_x = 4;
        #1;
        checks++; if (fwd_b !== 2'd2) begin errors++; $display("FAIL fwd_b_y_nowrite: got %0d want 2", fwd_b); end
        regwrite_z = 0;
        #1;
        checks++; if (fwd_b !== 2'd0) begin errors++; $display("FAIL fwd_b_z_nowrite: got %0d want 0", fwd_b); end
    endtask

    task automatic test_uart_read;
        int ack_cnt;
        int held;
        do_reset();
        ack_cnt = 0;
        held = 0;
        uart_rd_y = 1; rx_valid = 0;
        regwrite_y = 1; memtoreg_y = 1; wa_y = 6; rs_x = 6; use_rs_x = 1;
        #1;
        checks++; if ({stall_y, bubble_y} !== 2'b10) begin errors++; $display("FAIL iob_over_ldu: got %b want 10", {stall_y, bubble_y}); end
        if (stall_pc && stall_x && stall_y) held++;
        if (rx_ack) ack_cnt++;
        use_rs_x = 0;
        for (int i = 2; i <= 5; i++) begin
            tick();
            if (stall_pc && stall_x && stall_y) held++;
            if (rx_ack) ack_cnt++;
        end
        checks++; if (held !== 5) begin errors++; $display("FAIL rd_held_cycles: got %0d want 5", held); end
        tick();
        rx_valid = 1;
        #1;
        checks++; if ({stall_pc, stall_x, stall_y} !== 3'b000) begin errors++; $display("FAIL rd_release: got %b want 000", {stall_pc, stall_x, stall_y}); end
        if (rx_ack) ack_cnt++;
        tick();
        uart_rd_y = 0;
        #1;
        if (rx_ack) ack_cnt++;
        checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL rd_ack_count: got %0d want 1", ack_cnt); end
        use_rs_x = 1;
        #1;
        checks++; if (bubble_y !== 1'b1) begin errors++; $display("FAIL rd_back_to_run: got %b want 1", bubble_y); end
        clear_inputs();
    endtask

    task automatic test_timeout_branch;
        do_reset();
        uart_wr_y = 1; tx_ready = 0; branch_taken_y = 1;
        #1;
        checks++; if ({stall_pc, flush_x, tx_strobe} !== 3'b100) begin errors++; $display("FAIL wr_enter: got %b want 100", {stall_pc, flush_x, tx_strobe}); end
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++; if (io_timeout !== 1'b0) begin errors++; $display("FAIL timeout_early_%0d: got %b want 0", k, io_timeout); end
        end
        checks++; if (flush_x !== 1'b0) begin errors++; $display("FAIL flush_deferred: got %b want 0", flush_x); end
        tick();
        checks++; if ({io_timeout, stall_pc} !== 2'b11) begin errors++; $display("FAIL timeout_set: got %b want 11", {io_timeout, stall_pc}); end
        tick();
        tx_ready = 1;
        #1;
        checks++; if ({tx_strobe, stall_pc, flush_x, io_timeout} !== 4'b1011) begin errors++; $display("FAIL wr_release: got %b want 1011", {tx_strobe, stall_pc, flush_x, io_timeout}); end
        tick();
        uart_wr_y = 0; branch_taken_y = 0; tx_ready = 0;
        tick();
        tick();
        checks++; if ({io_timeout, flush_x} !== 2'b10) begin errors++; $display("FAIL timeout_sticky: got %b want 10", {io_timeout, flush_x}); end
        rst = 1;
        tick();
        rst = 0;
        #1;
        checks++; if (io_timeout !== 1'b0) begin errors++; $display("FAIL timeout_cleared: got %b want 0", io_timeout); end
    endtask

    task automatic test_ext_stall;
        do_reset();
        stall = 1; branch_taken_y = 1; uart_rd_y = 1; rx_valid = 1; uart_wr_y = 1; tx_ready = 1;
        #1;
        checks++; if ({stall_pc, stall_x, stall_y} !== 3'b111) begin errors++; $display("FAIL ext_stalls: got %b want 111", {stall_pc, stall_x, stall_y}); end
        checks++; if ({flush_x, rx_ack, tx_strobe, bubble_y} !== 4'b0000) begin errors++; $display("FAIL ext_masked: got %b want 0000", {flush_x, rx_ack, tx_strobe, bubble_y}); end
        tick();
        tick();
        stall = 0;
        #1;
        checks++; if ({flush_x, rx_ack, tx_strobe, stall_pc} !== 4'b1110) begin errors++; $display("FAIL ext_release: got %b want 1110", {flush_x, rx_ack, tx_strobe, stall_pc}); end
        tick();
        clear_inputs();
        #1;
        checks++; if (flush_x !== 1'b0) begin errors++; $display("FAIL flush_one_cycle: got %b want 0", flush_x); end
        stall = 1; regwrite_y = 1; memtoreg_y = 1; wa_y = 9; rt_x = 9; use_rt_x = 1;
        #1;
        checks++; if ({bubble_y, stall_y} !== 2'b01) begin errors++; $display("FAIL ext_ldu_masked: got %b want 01", {bubble_y, stall_y}); end
        tick();
        tick();
        stall = 0;
        #1;
        checks++; if ({bubble_y, stall_pc, stall_y} !== 3'b110) begin errors++; $display("FAIL ext_fsm_hold: got %b want 110", {bubble_y, stall_pc, stall_y}); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_io;
        do_reset();
        uart_rd_y = 1; rx_valid = 0;
        tick();
        tick();
        rst = 1;
        #1;
        checks++; if ({flush_x, stall_pc, stall_y} !== 3'b100) begin errors++; $display("FAIL rst_in_io: got %b want 100", {flush_x, stall_pc, stall_y}); end
        tick();
        rst = 0; uart_rd_y = 0;
        #1;
        checks++; if ({stall_pc, stall_x, stall_y} !== 3'b000) begin errors++; $display("FAIL rst_io_stalls: got %b want 000", {stall_pc, stall_x, stall_y}); end
`ifdef PIPELINE_CTRL_PERF_EN
        checks++; if (cycle_cnt !== 32'd0) begin errors++; $display("FAIL rst_io_cycle_cnt: got %0d want 0", cycle_cnt); end
`endif
        regwrite_y = 1; memtoreg_y = 1; wa_y = 8; rs_x = 8; use_rs_x = 1;
        #1;
        checks++; if (bubble_y !== 1'b1) begin errors++; $display("FAIL rst_io_run: got %b want 1", bubble_y); end
        clear_inputs();
    endtask

    initial begin
        rst = 1;
        clear_inputs();
        tick();
        test_reset();
        test_load_use();
        test_forwarding();
        test_uart_read();
        test_timeout_branch();
        test_ext_stall();
        test_reset_mid_io();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
